// File: rtl/maze_move_resolver.sv
// maze_move_resolver: resolves one maze move per request against bounds and an external synchronous wall RAM
module maze_move_resolver #(
    parameter logic [5:0] START_POS = 6'o11,
    parameter logic [5:0] GOAL_POS = 6'o66,
    parameter logic [2:0] X_MAX = 3'd6,
    parameter logic [2:0] Y_MAX = 3'd6
) (
    input logic clock,
    input logic reset,
    input logic move_valid,
    input logic [1:0] move_dir,
    output logic move_ready,
    output logic [5:0] wall_addr,
    input logic wall_q,
    output logic [5:0] position,
    output logic result_valid,
    output logic result_legal,
    output logic at_goal,
    output logic [7:0] move_count
);
    typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, COMMIT} state_t;
    state_t state, state_next;
    logic [5:0] cand, cand_next;
    logic [2:0] nx, ny;
    logic accept, legal;
    assign move_ready = (state == IDLE) && !at_goal;
    assign accept = move_valid && move_ready;
    assign result_valid = state == COMMIT;
    assign wall_addr = (state == LOOKUP || state == WAIT) ? cand : position;
    assign legal = cand[5:3] != 3'd0 && cand[5:3] <= X_MAX && cand[2:0] != 3'd0 && cand[2:0] <= Y_MAX && !wall_q;
    always_comb begin
        nx = move_dir == 2'd0 ? position[5:3] - 3'd1 : move_dir == 2'd1 ? position[5:3] + 3'd1 : position[5:3];
        ny = move_dir == 2'd2 ? position[2:0] - 3'd1 : move_dir == 2'd3 ? position[2:0] + 3'd1 : position[2:0];
        cand_next = accept ? {nx, ny} : cand;
        state_next = state == IDLE ? (accept ? LOOKUP : IDLE) :
                     state == LOOKUP ? WAIT :
                     state == WAIT ? COMMIT : IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cand <= START_POS;
            position <= START_POS;
            result_legal <= 1'b0;
            at_goal <= START_POS == GOAL_POS;
            move_count <= 8'd0;
        end else begin
            state <= state_next;
            cand <= cand_next;
            if (state == WAIT) begin
                result_legal <= legal;
                if (legal) begin
                    position <= cand;
                    move_count <= move_count + {7'd0, move_count != 8'hff};
                    if (cand == GOAL_POS) at_goal <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_maze_move_resolver.sv
// tb_maze_move_resolver: random and directed moves checked against a transaction-level maze model
module tb_maze_move_resolver;
    logic clock = 1'b0, reset = 1'b1, move_valid = 1'b0, wall_q = 1'b0;
    logic [1:0] move_dir = 2'd0;
    logic move_ready, result_valid, result_legal, at_goal;
    logic [5:0] wall_addr, position;
    logic [7:0] move_count;
    logic mem [64];
    int checks = 0, failures = 0;
    int ex, ey, ecount, k, ecx, ecy, cyc;
    bit egoal, elegal;
    bit [31:0] acc_mask, rv_mask;

    maze_move_resolver dut (
        .clock(clock), .reset(reset), .move_valid(move_valid), .move_dir(move_dir),
        .move_ready(move_ready), .wall_addr(wall_addr), .wall_q(wall_q), .position(position),
        .result_valid(result_valid), .result_legal(result_legal), .at_goal(at_goal),
        .move_count(move_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) wall_q <= mem[wall_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit mv, input logic [1:0] d, input bit rst);
        int dx, dy;
        move_valid = mv;
        move_dir = d;
        reset = rst;
        if (move_ready && mv && cyc < 32) acc_mask[cyc] = 1'b1;
        @(posedge clock);
        if (rst) begin
            ex = 1; ey = 1; ecount = 0; k = 0; elegal = 0; egoal = 0;
        end else if (k == 0) begin
            if (mv && !egoal) begin
                dx = d == 0 ? -1 : d == 1 ? 1 : 0;
                dy = d == 2 ? -1 : d == 3 ? 1 : 0;
                ecx = (ex + dx + 8) % 8;
                ecy = (ey + dy + 8) % 8;
                k = 1;
            end
        end else if (k == 2) begin
            elegal = ecx >= 1 && ecx <= 6 && ecy >= 1 && ecy <= 6 && mem[ecx * 8 + ecy] == 1'b0;
            if (elegal) begin
                ex = ecx; ey = ecy;
                if (ecount < 255) ecount++;
                if (ex == 6 && ey == 6) egoal = 1;
            end
            k = 3;
        end else k = (k + 1) % 4;
        #1;
        cyc++;
        if (result_valid && cyc < 32) rv_mask[cyc] = 1'b1;
        chk("ready", move_ready, k == 0 && !egoal);
        chk("rvalid", result_valid, k == 3);
        chk("rlegal", result_legal, elegal);
        chk("pos", position, ex * 8 + ey);
        chk("count", move_count, ecount);
        chk("goal", at_goal, egoal);
        chk("waddr", wall_addr, (k == 1 || k == 2) ? ecx * 8 + ecy : ex * 8 + ey);
        move_valid = 1'b0;
    endtask

    task automatic move(input logic [1:0] d);
        step(1'b1, d, 1'b0);
        repeat (3) step(1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 1'b0;
        cyc = 0;
        step(1'b0, 2'd0, 1'b1);
        chk("rst_pos", position, 6'o11);
        move(2'd1);
        chk("right_pos", position, 6'o21);
        chk("right_cnt", move_count, 8'd1);
        step(1'b0, 2'd0, 1'b1);
        move(2'd0);
        chk("left_oob", result_legal, 1'b0);
        chk("left_pos", position, 6'o11);
        mem[6'o12] = 1'b1;
        step(1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd3, 1'b0);
        chk("wall_lookup", wall_addr, 6'o12);
        repeat (3) step(1'b0, 2'd0, 1'b0);
        chk("wall_pos", position, 6'o11);
        mem[6'o12] = 1'b0;
        step(1'b0, 2'd0, 1'b1);
        cyc = 0; acc_mask = 0; rv_mask = 0;
        for (int i = 0; i < 11; i++) step(i < 10, 2'd1, 1'b0);
        chk("acc_cycles", acc_mask, 32'h111);
        chk("rv_cycles", rv_mask, 32'h888);
        step(1'b0, 2'd0, 1'b1);
        repeat (5) move(2'd1);
        repeat (5) move(2'd3);
        chk("at_goal", at_goal, 1'b1);
        repeat (6) step(1'b1, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd1, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b1, 2'd1, 1'b1);
        step(1'b0, 2'd0, 1'b0);
        chk("abort_pos", position, 6'o11);
        step(1'b0, 2'd0, 1'b1);
        repeat (130) begin
            move(2'd1);
            move(2'd0);
        end
        chk("sat_cnt", move_count, 8'd255);
        for (int r = 0; r < 6; r++) begin
            foreach (mem[i]) mem[i] = $urandom_range(3) == 0;
            step(1'b0, 2'd0, 1'b1);
            repeat (400) step($urandom_range(1), 2'($urandom_range(3)), $urandom_range(199) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/maze_move_resolver.md
MAZE_MOVE_RESOLVER -- requirements
Module: maze_move_resolver

Interface
REQ-001 Parameter START_POS, default 6'o11, initial player position {x[5:3], y[2:0]}.
REQ-002 Parameter GOAL_POS, default 6'o66, exit cell; reaching it ends the game.
REQ-003 Parameter X_MAX, default 3'd6, highest legal x; legal x range is 1..X_MAX.
REQ-004 Parameter Y_MAX, default 3'd6, highest legal y; legal y range is 1..Y_MAX.
REQ-005 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port move_valid, input, 1 bit: move request; accepted only when move_ready=1.
REQ-008 Port move_dir, input, 2 bits: 0=left (x-1), 1=right (x+1), 2=up (y-1), 3=down (y+1).
REQ-009 Port move_ready, output, 1 bit: high only in IDLE with at_goal=0.
REQ-010 Port wall_addr, output, 6 bits: candidate cell address to the external wall RAM.
REQ-011 Port wall_q, input, 1 bit: wall RAM data, 1=wall; synchronous read, valid one cycle after wall_addr is sampled.
REQ-012 Port position, output, 6 bits: committed player position {x, y}.
REQ-013 Port result_valid, output, 1 bit: one-cycle pulse when a move is resolved.
REQ-014 Port result_legal, output, 1 bit: outcome of the last resolved move; held until the next result.
REQ-015 Port at_goal, output, 1 bit: sticky flag, set when position equals GOAL_POS.
REQ-016 Port move_count, output, 8 bits: number of legal moves committed.

Function
REQ-017 FSM states: IDLE, LOOKUP, WAIT, COMMIT; transitions: IDLE->LOOKUP on accept, LOOKUP->WAIT, WAIT->COMMIT, COMMIT->IDLE, all unconditional except accept.
REQ-018 Accept means move_valid=1 and move_ready=1 at a rising edge; at that edge move_dir is latched and the candidate is registered.
REQ-019 Candidate arithmetic is 3-bit per axis with modulo-8 wrap (x=0 left gives 7); only the moved axis changes.
REQ-020 In LOOKUP and WAIT, wall_addr equals the candidate; in IDLE and COMMIT, wall_addr equals position.
REQ-021 Move is legal iff candidate x is in 1..X_MAX, candidate y is in 1..Y_MAX, and wall_q sampled in WAIT is 0.
REQ-022 Out-of-bounds candidates take the same state path and latency; wall_q is ignored for them.
REQ-023 At the edge leaving WAIT: result_legal is updated; if legal, position takes the candidate value and move_count increments.
REQ-024 result_valid is high exactly in the COMMIT cycle, i.e. 3 edges after the accepting edge.
REQ-025 Illegal move: position and move_count are unchanged.
REQ-026 move_ready is 0 in LOOKUP, WAIT and COMMIT; move_valid in those cycles is dropped, not queued.
REQ-027 Maximum throughput is one accepted move every 4 cycles; back-to-back acceptance is possible in the first IDLE cycle after COMMIT.
REQ-028 move_count saturates at 255; a legal move at 255 still updates position.
REQ-029 at_goal sets at the same edge position becomes GOAL_POS and stays set until reset; while set, move_ready=0 and no request is accepted.

Reset
REQ-030 At a rising edge with reset=1: state=IDLE, position=START_POS, result_valid=0, result_legal=0, at_goal=(START_POS==GOAL_POS), move_count=0.
REQ-031 Reset overrides any in-flight move; no commit and no result_valid occurs for an aborted move.
REQ-032 If move_valid=1 and reset=1 at the same edge, reset wins and the request is discarded.

Verification
REQ-033 Reset; wall RAM all 0; move right at position 11 -> result_valid 3 edges later, result_legal=1, position=21, move_count=1.
REQ-034 Position 11, move left -> candidate 01 out of bounds -> result_legal=0, position=11, move_count unchanged.
REQ-035 Wall at address 12, position 11, move down -> wall_addr=12 in LOOKUP/WAIT, wall_q=1 -> result_legal=0, position=11.
REQ-036 move_valid held high for 10 cycles from IDLE -> exactly 3 accepts, at cycles 0, 4 and 8; result_valid at cycles 3, 7 and 11.
REQ-037 Path to 66 with no walls -> at_goal=1 on the final commit; later move_valid is ignored with move_ready=0; reset mid-WAIT -> position=START_POS and no result_valid.
